// File: rtl/object_render_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// Module  : object_render_arbiter_pkg
// Brief   : Shared widths, colour defaults and FSM encoding for the arbiter.
// Revision: 1.0
// =============================================================================
package object_render_arbiter_pkg;

    localparam int IDX_W       = 3;
    localparam int COLOR_W     = 12;
    localparam int COORD_W_DEF = 10;

    typedef logic [IDX_W-1:0]   obj_idx_t;
    typedef logic [COLOR_W-1:0] color_t;

    localparam color_t TRANSPARENT_DEF = 12'h000;
    localparam color_t BG_COLOR_DEF    = 12'h000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage : object_render_arbiter_pkg
`default_nettype wire

// File: rtl/object_render_arbiter_if.sv
`default_nettype none
// =============================================================================
// Module  : object_render_arbiter_if
// Brief   : Slot-table write, pixel request/result and object-ROM port bundle.
// Revision: 1.0
// =============================================================================
interface object_render_arbiter_if #(
    parameter int NUM_SLOTS = 4,
    parameter int COORD_W   = 10,
    parameter int SPRITE_W  = 32,
    parameter int SPRITE_H  = 32
);
    import object_render_arbiter_pkg::*;

    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int ROW_W  = $clog2(SPRITE_H);
    localparam int COL_W  = $clog2(SPRITE_W);

    logic                slot_wr_en;
    logic [SLOT_W-1:0]   slot_wr_addr;
    logic [COORD_W-1:0]  slot_wr_x;
    logic [COORD_W-1:0]  slot_wr_y;
    obj_idx_t            slot_wr_index;
    logic                slot_wr_enable;

    logic                pix_req;
    logic [COORD_W-1:0]  pix_x;
    logic [COORD_W-1:0]  pix_y;
    logic                pix_ready;

    logic                out_valid;
    color_t              out_color;
    logic                out_hit;
    logic [SLOT_W-1:0]   out_slot;

    logic [ROW_W-1:0]    rom_row;
    logic [COL_W-1:0]    rom_col;
    obj_idx_t            rom_index;
    color_t              rom_color;

    modport master (
        output slot_wr_en, slot_wr_addr, slot_wr_x, slot_wr_y, slot_wr_index, slot_wr_enable,
        output pix_req, pix_x, pix_y, rom_color,
        input  pix_ready, out_valid, out_color, out_hit, out_slot,
        input  rom_row, rom_col, rom_index
    );

    modport slave (
        input  slot_wr_en, slot_wr_addr, slot_wr_x, slot_wr_y, slot_wr_index, slot_wr_enable,
        input  pix_req, pix_x, pix_y, rom_color,
        output pix_ready, out_valid, out_color, out_hit, out_slot,
        output rom_row, rom_col, rom_index
    );

endinterface : object_render_arbiter_if
`default_nettype wire

// File: rtl/object_render_arbiter_slot_hit.sv
`default_nettype none
// =============================================================================
// Module  : object_slot_hit
// Brief   : Combinational bounds test of one slot against a pixel, plus offsets.
// Revision: 1.0
// =============================================================================
module object_slot_hit
    import object_render_arbiter_pkg::*;
#(
    parameter int COORD_W  = COORD_W_DEF,
    parameter int SPRITE_W = 32,
    parameter int SPRITE_H = 32,
    parameter int ROW_W    = $clog2(SPRITE_H),
    parameter int COL_W    = $clog2(SPRITE_W)
) (
    input  logic               en_i,
    input  obj_idx_t           index_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    input  logic [COORD_W-1:0] pix_x_i,
    input  logic [COORD_W-1:0] pix_y_i,
    output logic               hit_o,
    output logic [ROW_W-1:0]   row_o,
    output logic [COL_W-1:0]   col_o
);
    localparam int EXT_W = COORD_W + 1;

    // One extra bit so an object near the right/bottom edge never wraps to 0.
    logic [EXT_W-1:0] w_px, w_py, w_x0, w_y0, w_x1, w_y1;

    assign w_px = {1'b0, pix_x_i};
    assign w_py = {1'b0, pix_y_i};
    assign w_x0 = {1'b0, x_i};
    assign w_y0 = {1'b0, y_i};
    assign w_x1 = w_x0 + EXT_W'(SPRITE_W);
    assign w_y1 = w_y0 + EXT_W'(SPRITE_H);

    assign hit_o = en_i && (index_i != '0)
                && (w_px >= w_x0) && (w_px < w_x1)
                && (w_py >= w_y0) && (w_py < w_y1);

    assign row_o = ROW_W'(pix_y_i - y_i);
    assign col_o = COL_W'(pix_x_i - x_i);

endmodule : object_slot_hit
`default_nettype wire

// File: rtl/object_render_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : object_render_arbiter
// Brief   : Probes covering object slots in priority order over one ROM port.
// Revision: 1.0
// =============================================================================
module object_render_arbiter
    import object_render_arbiter_pkg::*;
#(
    parameter int     NUM_SLOTS   = 4,
    parameter int     COORD_W     = COORD_W_DEF,
    parameter int     SPRITE_W    = 32,
    parameter int     SPRITE_H    = 32,
    parameter int     ROM_LATENCY = 1,
    parameter color_t TRANSPARENT = TRANSPARENT_DEF,
    parameter color_t BG_COLOR    = BG_COLOR_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    object_render_arbiter_if.slave  bus
);
    localparam int SLOT_W = $clog2(NUM_SLOTS);
    localparam int ROW_W  = $clog2(SPRITE_H);
    localparam int COL_W  = $clog2(SPRITE_W);
    localparam int CNT_W  = $clog2(ROM_LATENCY + 1);

    // Slot table
    logic [NUM_SLOTS-1:0] slot_en_q;
    logic [COORD_W-1:0]   slot_x_q   [NUM_SLOTS];
    logic [COORD_W-1:0]   slot_y_q   [NUM_SLOTS];
    obj_idx_t             slot_idx_q [NUM_SLOTS];

    // Per-slot hit results for the pixel currently on the request bus
    logic [NUM_SLOTS-1:0] w_hit;
    logic [ROW_W-1:0]     w_row [NUM_SLOTS];
    logic [COL_W-1:0]     w_col [NUM_SLOTS];

    // Snapshot taken on accept so slot writes cannot disturb the pixel in flight
    logic [NUM_SLOTS-1:0] pend_q;
    logic [ROW_W-1:0]     lat_row_q [NUM_SLOTS];
    logic [COL_W-1:0]     lat_col_q [NUM_SLOTS];
    obj_idx_t             lat_idx_q [NUM_SLOTS];

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q;
    logic [SLOT_W-1:0]    cur_slot_q;
    logic [ROW_W-1:0]     rom_row_q;
    logic [COL_W-1:0]     rom_col_q;
    obj_idx_t             rom_idx_q;
    color_t               out_color_q;
    logic                 out_hit_q;
    logic [SLOT_W-1:0]    out_slot_q;

    logic                 w_ready, w_valid, w_accept, w_last, w_opaque;
    logic [SLOT_W-1:0]    w_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_en_q <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                slot_x_q[s]   <= '0;
                slot_y_q[s]   <= '0;
                slot_idx_q[s] <= '0;
            end
        end else if (bus.slot_wr_en) begin
            slot_en_q[bus.slot_wr_addr]  <= bus.slot_wr_enable;
            slot_x_q[bus.slot_wr_addr]   <= bus.slot_wr_x;
            slot_y_q[bus.slot_wr_addr]   <= bus.slot_wr_y;
            slot_idx_q[bus.slot_wr_addr] <= bus.slot_wr_index;
        end
    end

    generate
        for (genvar s = 0; s < NUM_SLOTS; s++) begin : g_slot
            object_slot_hit #(
                .COORD_W  (COORD_W),
                .SPRITE_W (SPRITE_W),
                .SPRITE_H (SPRITE_H),
                .ROW_W    (ROW_W),
                .COL_W    (COL_W)
            ) u_hit (
                .en_i    (slot_en_q[s]),
                .index_i (slot_idx_q[s]),
                .x_i     (slot_x_q[s]),
                .y_i     (slot_y_q[s]),
                .pix_x_i (bus.pix_x),
                .pix_y_i (bus.pix_y),
                .hit_o   (w_hit[s]),
                .row_o   (w_row[s]),
                .col_o   (w_col[s])
            );
        end
    endgenerate

    // Lowest pending slot has priority
    always_comb begin
        w_sel = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (pend_q[i]) w_sel = SLOT_W'(i);
        end
    end

    assign w_accept = bus.pix_req && w_ready;
    assign w_last   = (cnt_q == CNT_W'(1));
    assign w_opaque = (bus.rom_color != TRANSPARENT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (w_accept) state_d = (|w_hit) ? ST_ISSUE : ST_DONE;
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (w_last) begin
                    if (w_opaque)    state_d = ST_DONE;
                    else if (|pend_q) state_d = ST_ISSUE;
                    else             state_d = ST_DONE;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        w_ready = (state_q == ST_IDLE);
        w_valid = (state_q == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= '0;
            cnt_q       <= '0;
            cur_slot_q  <= '0;
            rom_row_q   <= '0;
            rom_col_q   <= '0;
            rom_idx_q   <= '0;
            out_color_q <= '0;
            out_hit_q   <= 1'b0;
            out_slot_q  <= '0;
            for (int s = 0; s < NUM_SLOTS; s++) begin
                lat_row_q[s] <= '0;
                lat_col_q[s] <= '0;
                lat_idx_q[s] <= '0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_accept) begin
                        pend_q <= w_hit;
                        for (int s = 0; s < NUM_SLOTS; s++) begin
                            lat_row_q[s] <= w_row[s];
                            lat_col_q[s] <= w_col[s];
                            lat_idx_q[s] <= slot_idx_q[s];
                        end
                        if (w_hit == '0) begin
                            out_color_q <= BG_COLOR;
                            out_hit_q   <= 1'b0;
                            out_slot_q  <= '0;
                        end
                    end
                end
                ST_ISSUE: begin
                    rom_idx_q      <= lat_idx_q[w_sel];
                    rom_row_q      <= lat_row_q[w_sel];
                    rom_col_q      <= lat_col_q[w_sel];
                    cur_slot_q     <= w_sel;
                    pend_q[w_sel]  <= 1'b0;
                    cnt_q          <= CNT_W'(ROM_LATENCY);
                end
                ST_WAIT: begin
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (w_last) begin
                        if (w_opaque) begin
                            out_color_q <= bus.rom_color;
                            out_hit_q   <= 1'b1;
                            out_slot_q  <= cur_slot_q;
                        end else if (pend_q == '0) begin
                            out_color_q <= BG_COLOR;
                            out_hit_q   <= 1'b0;
                            out_slot_q  <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.pix_ready = w_ready;
    assign bus.out_valid = w_valid;
    assign bus.out_color = out_color_q;
    assign bus.out_hit   = out_hit_q;
    assign bus.out_slot  = out_slot_q;
    assign bus.rom_row   = rom_row_q;
    assign bus.rom_col   = rom_col_q;
    assign bus.rom_index = rom_idx_q;

endmodule : object_render_arbiter
`default_nettype wire

// File: tb/tb_object_render_arbiter.sv
`default_nettype none
// =============================================================================
// Module  : tb_object_render_arbiter
// Brief   : Directed and randomized checks against a per-pixel behavioural model.
// Revision: 1.0
// =============================================================================
module tb_object_render_arbiter;

    localparam int NS = 4;
    localparam int CW = 10;
    localparam int SW = 32;
    localparam int SH = 32;
    localparam int L  = 1;
    localparam int TRANSP = 0;
    localparam int BG     = 0;

    logic clk;
    logic rst_n;

    object_render_arbiter_if #(.NUM_SLOTS(NS), .COORD_W(CW), .SPRITE_W(SW), .SPRITE_H(SH)) bus_if ();

    object_render_arbiter #(
        .NUM_SLOTS(NS), .COORD_W(CW), .SPRITE_W(SW), .SPRITE_H(SH),
        .ROM_LATENCY(L), .TRANSPARENT(12'h000), .BG_COLOR(12'h000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Object ROM image: indices 2/3/4 are solid colours, the rest a patterned hash.
    function automatic int rom_fn(input int idx, input int row, input int col);
        int h;
        case (idx)
            2:       h = 'hF00;
            3:       h = 0;
            4:       h = 'h0F0;
            default: begin
                h = (idx * 977 + row * 61 + col * 7 + 1) & 'hFFF;
                if (((row * 3 + col + idx) % 4) == 0) h = 0;
            end
        endcase
        return h;
    endfunction

    always_comb bus_if.rom_color = 12'(rom_fn(int'(bus_if.rom_index), int'(bus_if.rom_row), int'(bus_if.rom_col)));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_results = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", nm, act, act, exp, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Behavioural model state
    int m_en [NS], m_x [NS], m_y [NS], m_idx [NS];
    bit busy = 0;
    int acc_cyc, done_cyc, m_probes;
    int p_idx [NS], p_row [NS], p_col [NS];
    int e_color, e_hit, e_slot;
    int last_lat, last_color, last_hit, last_slot;
    int last_p0_idx, last_p0_row, last_p0_col;

    always @(negedge clk) begin : monitor
        bit rdy, exp_v, found;
        int px, py, c, first;
        if (!rst_n) begin
            chk("rst_pix_ready", int'(bus_if.pix_ready), 1);
            chk("rst_out_valid", int'(bus_if.out_valid), 0);
            chk("rst_out_color", int'(bus_if.out_color), 0);
            chk("rst_out_hit",   int'(bus_if.out_hit), 0);
            chk("rst_out_slot",  int'(bus_if.out_slot), 0);
            chk("rst_rom_row",   int'(bus_if.rom_row), 0);
            chk("rst_rom_col",   int'(bus_if.rom_col), 0);
            chk("rst_rom_index", int'(bus_if.rom_index), 0);
            for (int s = 0; s < NS; s++) begin
                m_en[s] = 0; m_x[s] = 0; m_y[s] = 0; m_idx[s] = 0;
            end
            busy = 0;
        end else begin
            rdy   = !busy;
            exp_v = busy && (cyc == done_cyc);
            chk("pix_ready", int'(bus_if.pix_ready), int'(rdy));
            chk("out_valid", int'(bus_if.out_valid), int'(exp_v));
            if (exp_v) begin
                chk("out_color", int'(bus_if.out_color), e_color);
                chk("out_hit",   int'(bus_if.out_hit), e_hit);
                chk("out_slot",  int'(bus_if.out_slot), e_slot);
                last_lat   = cyc - acc_cyc;
                last_color = int'(bus_if.out_color);
                last_hit   = int'(bus_if.out_hit);
                last_slot  = int'(bus_if.out_slot);
                n_results++;
                busy = 0;
            end else if (busy) begin
                for (int k = 0; k < m_probes; k++) begin
                    first = acc_cyc + 2 + k * (L + 1);
                    if (cyc >= first && cyc < first + L) begin
                        chk("rom_index", int'(bus_if.rom_index), p_idx[k]);
                        chk("rom_row",   int'(bus_if.rom_row), p_row[k]);
                        chk("rom_col",   int'(bus_if.rom_col), p_col[k]);
                        if (k == 0 && cyc == first) begin
                            last_p0_idx = int'(bus_if.rom_index);
                            last_p0_row = int'(bus_if.rom_row);
                            last_p0_col = int'(bus_if.rom_col);
                        end
                    end
                end
            end
            if (rdy && bus_if.pix_req) begin
                px = int'(bus_if.pix_x);
                py = int'(bus_if.pix_y);
                m_probes = 0; found = 0;
                e_color = BG; e_hit = 0; e_slot = 0;
                for (int s = 0; s < NS; s++) begin
                    if (!found && m_en[s] != 0 && m_idx[s] != 0 &&
                        px >= m_x[s] && px < m_x[s] + SW &&
                        py >= m_y[s] && py < m_y[s] + SH) begin
                        p_idx[m_probes] = m_idx[s];
                        p_row[m_probes] = py - m_y[s];
                        p_col[m_probes] = px - m_x[s];
                        c = rom_fn(m_idx[s], py - m_y[s], px - m_x[s]);
                        m_probes++;
                        if (c != TRANSP) begin
                            found = 1; e_hit = 1; e_color = c; e_slot = s;
                        end
                    end
                end
                acc_cyc  = cyc;
                done_cyc = cyc + 1 + m_probes * (L + 1);
                busy     = 1;
            end
            if (bus_if.slot_wr_en) begin
                m_en[bus_if.slot_wr_addr]  = int'(bus_if.slot_wr_enable);
                m_x[bus_if.slot_wr_addr]   = int'(bus_if.slot_wr_x);
                m_y[bus_if.slot_wr_addr]   = int'(bus_if.slot_wr_y);
                m_idx[bus_if.slot_wr_addr] = int'(bus_if.slot_wr_index);
            end
        end
    end

    task automatic write_slot(input int a, input int x, input int y, input int idx, input int en);
        bus_if.slot_wr_addr   = 2'(a);
        bus_if.slot_wr_x      = CW'(x);
        bus_if.slot_wr_y      = CW'(y);
        bus_if.slot_wr_index  = 3'(idx);
        bus_if.slot_wr_enable = (en != 0);
        bus_if.slot_wr_en     = 1'b1;
        @(posedge clk); #1;
        bus_if.slot_wr_en     = 1'b0;
    endtask

    task automatic start_req(input int x, input int y, output int r0);
        bit acc;
        r0 = n_results;
        acc = 0;
        bus_if.pix_x   = CW'(x);
        bus_if.pix_y   = CW'(y);
        bus_if.pix_req = 1'b1;
        for (int t = 0; t < 40 && !acc; t++) begin
            @(negedge clk);
            acc = bus_if.pix_ready;
            @(posedge clk); #1;
        end
        bus_if.pix_req = 1'b0;
        if (!acc) chk("req_accept_timeout", 0, 1);
    endtask

    task automatic wait_result(input int r0);
        for (int t = 0; t < 60 && n_results == r0; t++) begin
            @(posedge clk); #1;
        end
        if (n_results == r0) chk("result_timeout", 0, 1);
    endtask

    task automatic run_req(input int x, input int y);
        int r0;
        start_req(x, y, r0);
        wait_result(r0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        int r0;
        bus_if.slot_wr_en = 0; bus_if.slot_wr_addr = '0; bus_if.slot_wr_x = '0;
        bus_if.slot_wr_y = '0; bus_if.slot_wr_index = '0; bus_if.slot_wr_enable = 0;
        bus_if.pix_req = 0; bus_if.pix_x = '0; bus_if.pix_y = '0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Empty table: background after one cycle
        run_req(100, 100);
        chk("bg_latency", last_lat, 1);
        chk("bg_color", last_color, 0);
        chk("bg_hit", last_hit, 0);

        // Single opaque slot
        write_slot(0, 64, 48, 2, 1);
        run_req(70, 50);
        chk("one_latency", last_lat, 3);
        chk("one_color", last_color, 'hF00);
        chk("one_slot", last_slot, 0);
        chk("one_rom_index", last_p0_idx, 2);
        chk("one_rom_row", last_p0_row, 2);
        chk("one_rom_col", last_p0_col, 6);

        // Transparent slot 0 over opaque slot 1
        write_slot(0, 64, 48, 3, 1);
        write_slot(1, 60, 40, 4, 1);
        run_req(70, 50);
        chk("two_latency", last_lat, 5);
        chk("two_slot", last_slot, 1);
        chk("two_color", last_color, 'h0F0);
        chk("two_hit", last_hit, 1);

        // Screen-edge and no-wrap boundaries
        write_slot(0, 0, 0, 0, 0);
        write_slot(1, 0, 0, 0, 0);
        write_slot(2, 608, 448, 2, 1);
        write_slot(3, 1000, 0, 2, 1);
        run_req(639, 479);
        chk("edge_hit", last_hit, 1);
        chk("edge_slot", last_slot, 2);
        chk("edge_row", last_p0_row, 31);
        chk("edge_col", last_p0_col, 31);
        run_req(640, 479);
        chk("edge_miss_latency", last_lat, 1);
        chk("edge_miss_hit", last_hit, 0);
        run_req(10, 5);
        chk("nowrap_hit", last_hit, 0);
        run_req(1023, 5);
        chk("far_right_slot", last_slot, 3);
        chk("far_right_col", last_p0_col, 23);

        // Rewrite slot 0 while its probe waits on the ROM
        write_slot(2, 0, 0, 0, 0);
        write_slot(3, 0, 0, 0, 0);
        write_slot(0, 64, 48, 2, 1);
        start_req(70, 50, r0);
        @(posedge clk); #1;
        write_slot(0, 0, 0, 4, 1);
        wait_result(r0);
        chk("rewrite_color", last_color, 'hF00);
        chk("rewrite_row", last_p0_row, 2);
        chk("rewrite_col", last_p0_col, 6);
        run_req(5, 5);
        chk("rewrite_next_color", last_color, 'h0F0);
        chk("rewrite_next_row", last_p0_row, 5);
        chk("rewrite_next_idx", last_p0_idx, 4);

        // Asynchronous reset in the middle of a probe
        start_req(5, 5, r0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("abort_pix_ready_now", int'(bus_if.pix_ready), 1);
        chk("abort_rom_index_now", int'(bus_if.rom_index), 0);
        chk("abort_out_color_now", int'(bus_if.out_color), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("abort_no_result", n_results, r0);
        chk("abort_ready_after", int'(bus_if.pix_ready), 1);

        // Randomized traffic, including writes while a pixel is in flight
        for (int it = 0; it < 200; it++) begin
            int nw;
            nw = int'($urandom_range(0, 2));
            for (int w = 0; w < nw; w++)
                write_slot(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 60)),
                           int'($urandom_range(0, 60)), int'($urandom_range(0, 7)),
                           int'($urandom_range(0, 3) != 0));
            start_req(int'($urandom_range(0, 100)), int'($urandom_range(0, 100)), r0);
            if ($urandom_range(0, 2) == 0)
                write_slot(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 60)),
                           int'($urandom_range(0, 60)), int'($urandom_range(0, 7)), 1);
            wait_result(r0);
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_object_render_arbiter
`default_nettype wire
